// File: rtl/enemy_lane_scheduler.sv
// Per-frame enemy lane sequencer: owns every lane's y position and alive flag and
// walks lanes 0..NLANES-1 one per cycle after each accepted frame tick.
module enemy_lane_scheduler #(
    parameter int unsigned NLANES    = 8,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned Y_SPAWN   = 0,
    parameter int unsigned Y_HIDDEN  = 1023,
    parameter int unsigned Y_LIMIT   = 400,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FRAME_DIV = 4,
    parameter int unsigned KILL_MAX  = 99
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  frame_tick,
    input  logic [NLANES-1:0]     spawn_req,
    input  logic [NLANES-1:0]     hit,
    output logic [NLANES*Y_W-1:0] enemy_y,
    output logic [NLANES-1:0]     alive,
    output logic                  busy,
    output logic                  kill_pulse,
    output logic [6:0]            kill_cnt,
    output logic                  breach,
    output logic [NLANES-1:0]     breach_mask
);
    localparam int unsigned IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [IDX_W-1:0] LastLane = IDX_W'(NLANES - 1);
    localparam logic [DIV_W-1:0] LastDiv  = DIV_W'(FRAME_DIV - 1);
    localparam logic [Y_W-1:0]   YHidden  = Y_W'(Y_HIDDEN);
    localparam logic [Y_W-1:0]   YSpawn   = Y_W'(Y_SPAWN);
    localparam logic [Y_W:0]     YLimit   = (Y_W + 1)'(Y_LIMIT);
    localparam logic [Y_W:0]     YStep    = (Y_W + 1)'(STEP);
    localparam logic [6:0]       KillMax  = 7'(KILL_MAX);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q;
    logic [Y_W-1:0]    y_q [NLANES];
    logic [NLANES-1:0] spawn_p;
    logic [NLANES-1:0] hit_p;
    logic [NLANES-1:0] acc_q;
    logic [IDX_W-1:0]  lane_q;
    logic [DIV_W-1:0]  div_q;
    logic              move_q;

    logic [NLANES-1:0] lane_sel;
    logic [NLANES-1:0] acc_next;
    logic [NLANES-1:0] spawn_clr;
    logic [Y_W-1:0]    cur_y;
    logic [Y_W:0]      y_sum;
    logic              scanning;
    logic              cur_alive;
    logic              do_kill;
    logic              do_breach;
    logic              do_move;
    logic              do_spawn;

    // One shared adder/comparator serves whichever lane the scan is on.
    always_comb begin
        scanning  = (state_q == StScan);
        lane_sel  = '0;
        if (scanning) lane_sel[lane_q] = 1'b1;
        cur_y     = y_q[lane_q];
        cur_alive = alive[lane_q];
        y_sum     = {1'b0, cur_y} + YStep;
        do_kill   = scanning && cur_alive && hit_p[lane_q];
        do_breach = scanning && cur_alive && !hit_p[lane_q] && move_q && (y_sum >= YLimit);
        do_move   = scanning && cur_alive && !hit_p[lane_q] && move_q && (y_sum < YLimit);
        do_spawn  = scanning && !cur_alive && spawn_p[lane_q];
        acc_next  = acc_q | (do_breach ? lane_sel : '0);
        spawn_clr = do_kill ? '0 : lane_sel;
        kill_pulse = do_kill;
        for (int i = 0; i < NLANES; i++) begin
            enemy_y[i*Y_W +: Y_W] = y_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < NLANES; i++) y_q[i] <= YHidden;
            alive       <= '0;
            busy        <= 1'b0;
            kill_cnt    <= '0;
            breach      <= 1'b0;
            breach_mask <= '0;
            spawn_p     <= '0;
            hit_p       <= '0;
            acc_q       <= '0;
            lane_q      <= '0;
            div_q       <= '0;
            move_q      <= 1'b0;
        end else begin
            // A pulse landing on the lane being processed survives to the next scan.
            spawn_p <= (spawn_p & ~spawn_clr) | (enb ? spawn_req : '0);
            hit_p   <= (hit_p & ~lane_sel) | (enb ? hit : '0);
            unique case (state_q)
                StIdle: begin
                    if (frame_tick && enb) begin
                        state_q <= StScan;
                        busy    <= 1'b1;
                        lane_q  <= '0;
                        move_q  <= (div_q == LastDiv);
                        div_q   <= (div_q == LastDiv) ? '0 : div_q + 1'b1;
                    end
                end
                StScan: begin
                    if (do_kill) begin
                        alive[lane_q] <= 1'b0;
                        y_q[lane_q]   <= YHidden;
                        if (kill_cnt != KillMax) kill_cnt <= kill_cnt + 7'd1;
                    end else if (do_breach) begin
                        alive[lane_q] <= 1'b0;
                        y_q[lane_q]   <= YHidden;
                    end else if (do_move) begin
                        y_q[lane_q]   <= y_sum[Y_W-1:0];
                    end else if (do_spawn) begin
                        alive[lane_q] <= 1'b1;
                        y_q[lane_q]   <= YSpawn;
                    end
                    acc_q <= acc_next;
                    if (lane_q == LastLane) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        // Registered here so the pulse is visible during the DONE cycle.
                        if (|acc_next) begin
                            breach      <= 1'b1;
                            breach_mask <= acc_next;
                        end
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                end
                StDone: begin
                    breach  <= 1'b0;
                    acc_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_lane_scheduler.sv
// Self-checking bench for enemy_lane_scheduler: directed frame table, multi-cycle
// corner sequences and a randomized run against a frame-level reference model.
module tb_enemy_lane_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  spawn_req = '0;
    logic [7:0]  hit = '0;
    logic [79:0] enemy_y;
    logic [7:0]  alive;
    logic        busy;
    logic        kill_pulse;
    logic [6:0]  kill_cnt;
    logic        breach;
    logic [7:0]  breach_mask;

    enemy_lane_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .frame_tick  (frame_tick),
        .spawn_req   (spawn_req),
        .hit         (hit),
        .enemy_y     (enemy_y),
        .alive       (alive),
        .busy        (busy),
        .kill_pulse  (kill_pulse),
        .kill_cnt    (kill_cnt),
        .breach      (breach),
        .breach_mask (breach_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_n, kills_n, kill_at, breach_n, breach_at;

    typedef struct {
        logic       en;
        logic [7:0] sp;
        logic [7:0] ht;
        logic       tk;
        logic [7:0] exp_alive;
        int         exp_y0;
        int         exp_y2;
        int         exp_y3;
        int         exp_kills;
        int         exp_busy;
        int         exp_kill_at;
    } vec_t;
    vec_t vecs[13];

    // Frame-level reference model state.
    int         my[8];
    bit [7:0]   ma;
    bit [7:0]   msp, mhp, mmask;
    int         mdiv, mk, m_kills, m_breach;

    function automatic int lane_y(input int i);
        return int'(enemy_y[i*10 +: 10]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse requests for one cycle, then frame_tick, then observe 12 cycles.
    task automatic run_frame(input logic e, input logic [7:0] s, input logic [7:0] h,
                             input logic tk);
        @(negedge clk);
        enb = e; spawn_req = s; hit = h;
        @(negedge clk);
        spawn_req = '0; hit = '0; frame_tick = tk;
        @(negedge clk);
        frame_tick = 1'b0;
        busy_n = 0; kills_n = 0; kill_at = -1; breach_n = 0; breach_at = -1;
        for (int k = 0; k < 12; k++) begin
            if (busy) busy_n++;
            if (kill_pulse) begin
                kills_n++;
                if (kill_at < 0) kill_at = k;
            end
            if (breach) begin
                breach_n++;
                if (breach_at < 0) breach_at = k;
            end
            @(negedge clk);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) my[i] = 1023;
        ma = '0; msp = '0; mhp = '0; mmask = '0; mdiv = 0; mk = 0;
    endtask

    task automatic model_frame(input bit e, input bit [7:0] s, input bit [7:0] h, input bit tk);
        bit        mv;
        bit [7:0]  acc;
        m_kills = 0; m_breach = 0;
        if (e) begin
            msp |= s;
            mhp |= h;
        end
        if (!(e && tk)) return;
        mv   = (mdiv == 3);
        mdiv = (mdiv + 1) % 4;
        acc  = '0;
        for (int i = 0; i < 8; i++) begin
            bit killed = 1'b0;
            if (ma[i] && mhp[i]) begin
                ma[i] = 1'b0; my[i] = 1023; killed = 1'b1;
                m_kills++;
                if (mk < 99) mk++;
            end else if (ma[i] && mv && my[i] + 2 >= 400) begin
                ma[i] = 1'b0; my[i] = 1023; acc[i] = 1'b1;
            end else if (ma[i] && mv) begin
                my[i] += 2;
            end else if (!ma[i] && msp[i]) begin
                ma[i] = 1'b1; my[i] = 0;
            end
            mhp[i] = 1'b0;
            if (!killed) msp[i] = 1'b0;
        end
        if (acc != 0) begin
            mmask = acc;
            m_breach = 1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h05, 8'h00, 1'b1, 8'h05, 0, 0,    1023, 0, 8, -1};
        vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h05, 0, 0,    1023, 0, 8, -1};
        vecs[2]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h05, 0, 0,    1023, 0, 8, -1};
        vecs[3]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h05, 2, 2,    1023, 0, 8, -1};
        vecs[4]  = '{1'b1, 8'h00, 8'h04, 1'b1, 8'h01, 2, 1023, 1023, 1, 8, 2};
        vecs[5]  = '{1'b1, 8'h00, 8'h80, 1'b1, 8'h01, 2, 1023, 1023, 1, 8, -1};
        vecs[6]  = '{1'b1, 8'h80, 8'h00, 1'b1, 8'h81, 2, 1023, 1023, 1, 8, -1};
        vecs[7]  = '{1'b1, 8'h08, 8'h00, 1'b1, 8'h89, 4, 1023, 0,    1, 8, -1};
        vecs[8]  = '{1'b1, 8'h08, 8'h08, 1'b1, 8'h81, 4, 1023, 1023, 2, 8, 3};
        vecs[9]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h89, 4, 1023, 0,    2, 8, -1};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h89, 4, 1023, 0,    2, 0, -1};
        vecs[11] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h89, 4, 1023, 0,    2, 8, -1};
        vecs[12] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h89, 6, 1023, 2,    2, 8, -1};

        // Reset values
        do_reset();
        for (int i = 0; i < 8; i++) check($sformatf("reset_y%0d", i), lane_y(i), 1023);
        check("reset_alive", int'(alive), 0);
        check("reset_kill_cnt", int'(kill_cnt), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_breach", int'(breach), 0);
        check("reset_mask", int'(breach_mask), 0);
        check("reset_kill_pulse", int'(kill_pulse), 0);

        // Directed frame table: spawn, move, hit, dead-lane hit, same-slot hit+spawn, pause
        foreach (vecs[r]) begin
            run_frame(vecs[r].en, vecs[r].sp, vecs[r].ht, vecs[r].tk);
            check($sformatf("row%0d_alive", r), int'(alive), int'(vecs[r].exp_alive));
            check($sformatf("row%0d_y0", r), lane_y(0), vecs[r].exp_y0);
            check($sformatf("row%0d_y2", r), lane_y(2), vecs[r].exp_y2);
            check($sformatf("row%0d_y3", r), lane_y(3), vecs[r].exp_y3);
            check($sformatf("row%0d_kill_cnt", r), int'(kill_cnt), vecs[r].exp_kills);
            check($sformatf("row%0d_busy_cycles", r), busy_n, vecs[r].exp_busy);
            check($sformatf("row%0d_kill_at", r), kill_at, vecs[r].exp_kill_at);
        end

        // Kill counter saturation: 13 rounds of 8 kills
        do_reset();
        for (int r = 0; r < 13; r++) begin
            run_frame(1'b1, 8'hFF, 8'h00, 1'b1);
            run_frame(1'b1, 8'h00, 8'hFF, 1'b1);
            if (r == 0) check("sat_first_round", int'(kill_cnt), 8);
        end
        check("sat_kill_cnt", int'(kill_cnt), 99);
        check("sat_pulses_still", kills_n, 8);
        check("sat_alive", int'(alive), 0);

        // Hit arriving during its own lane's scan cycle is deferred one scan
        do_reset();
        run_frame(1'b1, 8'h02, 8'h00, 1'b1);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); hit = 8'h02;
        @(negedge clk); hit = 8'h00;
        for (int k = 0; k < 12 && (busy || breach); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("late_hit_busy_done", int'(busy), 0);
        check("late_hit_alive", int'(alive), 8'h02);
        check("late_hit_kill_cnt", int'(kill_cnt), 0);
        run_frame(1'b1, 8'h00, 8'h00, 1'b1);
        check("late_hit_next_alive", int'(alive), 0);
        check("late_hit_next_kill", int'(kill_cnt), 1);

        // Reset during scan cycle 3
        run_frame(1'b1, 8'hF0, 8'h00, 1'b1);
        check("pre_abort_alive", int'(alive), 8'hF1 & 8'hF0);
        @(negedge clk); hit = 8'h10; frame_tick = 1'b1;
        @(negedge clk); hit = 8'h00; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_alive", int'(alive), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_kill_cnt", int'(kill_cnt), 0);
        check("abort_y4", lane_y(4), 1023);
        repeat (3) @(negedge clk);
        check("abort_idle", int'(busy), 0);
        check("abort_kill_cnt_later", int'(kill_cnt), 0);

        // Breach: lane 0 climbs 2 px every 4th frame, 398 + 2 reaches 400 on frame 800
        do_reset();
        run_frame(1'b1, 8'h01, 8'h00, 1'b1);
        for (int f = 2; f <= 796; f++) run_frame(1'b1, 8'h00, 8'h00, 1'b1);
        check("pre_breach_y0", lane_y(0), 398);
        check("pre_breach_alive", int'(alive), 1);
        for (int f = 797; f <= 799; f++) run_frame(1'b1, 8'h00, 8'h00, 1'b1);
        check("hold_breach_y0", lane_y(0), 398);
        run_frame(1'b1, 8'h00, 8'h00, 1'b1);
        check("breach_pulses", breach_n, 1);
        check("breach_in_done", breach_at, 8);
        check("breach_mask", int'(breach_mask), 1);
        check("breach_alive", int'(alive), 0);
        check("breach_y0", lane_y(0), 1023);
        run_frame(1'b1, 8'h00, 8'h00, 1'b1);
        check("quiet_breach", breach_n, 0);
        check("quiet_mask_held", int'(breach_mask), 1);

        // Randomized frames against the reference model
        do_reset();
        model_reset();
        for (int f = 0; f < 120; f++) begin
            logic       e, tk;
            logic [7:0] s, h;
            e  = ($urandom_range(0, 7) != 0);
            tk = ($urandom_range(0, 5) != 0);
            s  = 8'($urandom) & 8'($urandom);
            h  = 8'($urandom) & 8'($urandom);
            run_frame(e, s, h, tk);
            model_frame(e, s, h, tk);
            check($sformatf("rnd%0d_alive", f), int'(alive), int'(ma));
            for (int i = 0; i < 8; i++)
                check($sformatf("rnd%0d_y%0d", f, i), lane_y(i), my[i]);
            check($sformatf("rnd%0d_kill_cnt", f), int'(kill_cnt), mk);
            check($sformatf("rnd%0d_kill_pulses", f), kills_n, m_kills);
            check($sformatf("rnd%0d_breach", f), breach_n, m_breach);
            check($sformatf("rnd%0d_mask", f), int'(breach_mask), int'(mmask));
            check($sformatf("rnd%0d_busy", f), busy_n, (e && tk) ? 8 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
